uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 Parameter: none; bit timing is set by the bit_period_i input.
- REQ-002 clk_i  input  1  system clock; all logic on the rising edge.
- REQ-003 resetn_i  input  1  reset, asynchronous, active-low.
- REQ-004 rx_i  input  1  serial line; idles high; asynchronous to clk_i.
- REQ-005 bit_period_i  input  16  clock cycles per bit; values below 16 are treated as 16.
- REQ-006 parity_en_i  input  1  1 = a parity bit follows the data bits.
- REQ-007 stopbit_i  input  1  0 = one stop bit; 1 = two stop bits.
- REQ-008 rx_data_o  output  8  last received byte; bit 0 is the first data bit after the start bit.
- REQ-009 rx_valid_o  output  1  one-cycle pulse when a frame completes.
- REQ-010 parity_err_o  output  1  parity mismatch for the frame flagged by rx_valid_o.
- REQ-011 frame_err_o  output  1  stop bit sampled low for the frame flagged by rx_valid_o.
- REQ-012 busy_o  output  1  high in every state except IDLE.

Function
- REQ-013 rx_i shall pass through a 2-flop synchronizer, reset value 1; all logic uses only the synchronized value rx_s.
- REQ-014 States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- REQ-015 The block shall latch bit_period_i and parity_en_i on IDLE->START, together with stopbit_i; changes mid-frame have no effect.
- REQ-016 IDLE->START when rx_s=0 and the armed flag is set; the bit counter is cleared.
- REQ-017 The armed flag shall be set whenever rx_s=1 in IDLE, and cleared on entering START.
- REQ-018 START: sample rx_s after floor(P/2) cycles, where P is the latched period; 1 -> IDLE (glitch, no pulse); 0 -> DATA, counter cleared.
- REQ-019 Every following sample shall occur P cycles after the previous one, giving mid-bit sampling.
- REQ-020 DATA: 8 samples shifted LSB-first into the shift register; then go to PARITY if parity is enabled, else STOP1.
- REQ-021 PARITY: one sample; parity error = sample XOR (XOR-reduction of the 8 data bits), i.e. even parity.
- REQ-022 STOP1: one sample; a low sample sets the frame error; go to STOP2 if two stop bits are selected, else DONE.
- REQ-023 STOP2: one sample, OR-ed into the frame error; then DONE.
- REQ-024 DONE, lasting one cycle:
  - rx_data_o <= shift register;
  - parity_err_o and frame_err_o <= the internal flags;
  - rx_valid_o=1;
  - next state IDLE.
- REQ-025 rx_data_o, parity_err_o and frame_err_o shall hold until the next DONE.
- REQ-026 Latency: rx_valid_o rises 1 cycle after the final stop-bit sample; the 2-cycle synchronizer delay precedes all samples.
- REQ-027 After a frame error, the block shall not start a new frame until rx_s has been seen high (armed flag); a held-low break yields exactly one error frame.
- REQ-028 A start edge arriving in the DONE cycle shall be accepted on the next IDLE cycle without loss.
- REQ-029 The bit counter shall be 16 bits and never wrap; it is cleared at each sample.

Reset
- REQ-030 resetn_i=0 shall asynchronously force:
  - state IDLE, armed flag 0;
  - synchronizer flops 1;
  - counters 0;
  - rx_data_o=0x00;
  - rx_valid_o, parity_err_o, frame_err_o and busy_o all 0.
- REQ-031 Reset mid-frame shall discard the partial byte and produce no rx_valid_o pulse; after release, reception resumes on the next falling edge seen after the line is high.

Verification
- REQ-032 Nominal frame, 100 MHz clock, bit_period_i=868 (115200 baud), parity_en_i=1, stopbit_i=1: send bytes 0x1C, 0x0D, 0x0D, 0x7F, 0x7F, each with parity bit 1 and two stop bits.
  - Required: five rx_valid_o pulses, data 1C 0D 0D 7F 7F, no errors.
- REQ-033 Parity error: send 0x55 with parity bit 1 -> rx_data_o=0x55, parity_err_o=1, frame_err_o=0.
- REQ-034 Framing/break: send 0xA3 with the stop bit low, then hold the line low for 30 bit periods.
  - Required: exactly one pulse with frame_err_o=1.
  - After the line returns high, a following 0x3C is received cleanly.
- REQ-035 Glitch: drive a 200 ns low pulse on an idle line -> busy_o pulses, no rx_valid_o, state returns to IDLE.
- REQ-036 Reset and config: assert resetn_i during data bit 4 of 0xF0 -> no pulse and all outputs 0; a following 0x81 is received correctly.
  - Repeat with bit_period_i=8: 16-cycle bits shall be used.
  - Repeat with parity_en_i=0, stopbit_i=0: 10-bit frame, rx_valid_o 1 cycle after the stop-bit sample.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver, 8 data bits, optional even parity,
// one or two stop bits, runtime-programmable bit period.
//
// Ports
//   clk_i         system clock, all logic on the rising edge
//   resetn_i      asynchronous active-low reset
//   rx_i          serial line (idles high, asynchronous to clk_i)
//   bit_period_i  clock cycles per bit; values below 16 are treated as 16
//   parity_en_i   1 = an even-parity bit follows the data bits
//   stopbit_i     0 = one stop bit, 1 = two stop bits
//   rx_data_o     last received byte (bit 0 = first data bit on the line)
//   rx_valid_o    one-cycle pulse when a frame completes
//   parity_err_o  parity mismatch for the frame flagged by rx_valid_o
//   frame_err_o   a stop bit was sampled low for the frame flagged by rx_valid_o
//   busy_o        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        rx_i,
    input  logic [15:0] bit_period_i,
    input  logic        parity_en_i,
    input  logic        stopbit_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE
    } state_t;

    localparam logic [15:0] MIN_PERIOD = 16'd16;

    state_t      state_q, state_d;

    logic        sync_q;      // first synchronizer stage
    logic        rx_s;        // synchronized line, the only view of rx_i used below
    logic        armed_q;     // line has been seen high since the last frame
    logic [15:0] cnt_q;       // cycles since the previous sample point
    logic [2:0]  bit_idx_q;   // data bit being received
    logic [7:0]  shift_q;
    logic [15:0] period_q;    // frame configuration captured at the start edge
    logic        par_en_q;
    logic        two_stop_q;
    logic        par_err_q;
    logic        frm_err_q;

    logic [15:0] target;
    logic        sample;
    logic        last_stop;
    logic        frm_next;
    logic        start_frame;

    // -------------------------------------------------------------------------
    // Synchronizer: resets to the idle line level so a reset never looks like
    // a start bit.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of the others.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= rx_i;
            rx_s   <= sync_q;
        end
    end

    // -------------------------------------------------------------------------
    // Sample timing: the first sample lands half a period into the start bit,
    // each later one a full period after the previous, i.e. mid-bit.
    // -------------------------------------------------------------------------
    assign target      = (state_q == START) ? {1'b0, period_q[15:1]} : period_q;
    assign sample      = (state_q inside {START, DATA, PARITY, STOP1, STOP2}) &&
                         (cnt_q == target - 16'd1);
    assign last_stop   = sample && ((state_q == STOP2) ||
                                    ((state_q == STOP1) && !two_stop_q));
    // The second stop bit accumulates onto the first one's error.
    assign frm_next    = ((state_q == STOP2) ? frm_err_q : 1'b0) | ~rx_s;
    assign start_frame = (state_q == IDLE) && (state_d == START);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and busy output
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != IDLE);
        unique case (state_q)
            IDLE:   if (!rx_s && armed_q) state_d = START;
            START:  if (sample) state_d = rx_s ? IDLE : DATA;  // high = glitch
            DATA:   if (sample && (bit_idx_q == 3'd7))
                        state_d = par_en_q ? PARITY : STOP1;
            PARITY: if (sample) state_d = STOP1;
            STOP1:  if (sample) state_d = two_stop_q ? STOP2 : DONE;
            STOP2:  if (sample) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath, configuration capture and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            period_q     <= MIN_PERIOD;
            par_en_q     <= 1'b0;
            two_stop_q   <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            // Cycle counter saturates instead of wrapping.
            if ((state_q == IDLE) || sample) begin
                cnt_q <= '0;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // Arming: a break (line held low) must not retrigger, so only a
            // high line in IDLE/DONE or a clean final stop bit re-arms. The
            // stop-bit case lets a start edge landing in DONE be accepted.
            if (start_frame) begin
                armed_q <= 1'b0;
            end else if (((state_q == IDLE) || (state_q == DONE)) && rx_s) begin
                armed_q <= 1'b1;
            end else if (last_stop && !frm_next) begin
                armed_q <= 1'b1;
            end

            if (start_frame) begin
                period_q   <= (bit_period_i < MIN_PERIOD) ? MIN_PERIOD : bit_period_i;
                par_en_q   <= parity_en_i;
                two_stop_q <= stopbit_i;
                bit_idx_q  <= '0;
                par_err_q  <= 1'b0;
                frm_err_q  <= 1'b0;
            end

            if (sample) begin
                unique case (state_q)
                    DATA: begin
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                    PARITY:       par_err_q <= rx_s ^ (^shift_q);
                    STOP1, STOP2: frm_err_q <= frm_next;
                    default: ;
                endcase
            end

            // Results are loaded on the final stop sample so they are already
            // stable during the DONE cycle that carries the valid pulse.
            if (last_stop) begin
                rx_data_o    <= shift_q;
                parity_err_o <= par_err_q;
                frame_err_o  <= frm_next;
            end
            rx_valid_o <= last_stop;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed, self-checking bench for uart_rx. A bit-banging
// transmitter pushes the expected byte, error flags and valid cycle onto a
// scoreboard; a monitor pops and compares on every rx_valid_o pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        rx_i;
    logic [15:0] bit_period_i;
    logic        parity_en_i;
    logic        stopbit_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        busy_o;

    uart_rx dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .rx_i         (rx_i),
        .bit_period_i (bit_period_i),
        .parity_en_i  (parity_en_i),
        .stopbit_i    (stopbit_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;  // 100 MHz

    // Edge index: after rising edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         exp_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    int   n_pushed = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_period(input int p);
        return (p < 16) ? 16 : p;
    endfunction

    // Monitor: every valid pulse must match the oldest scoreboard entry and
    // arrive within one cycle of the mid-bit sampling model.
    always @(negedge clk_i) begin
        if (rx_valid_o === 1'b1) begin
            n_pulses++;
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            check("pulse_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("rx_data", {24'd0, rx_data_o}, {24'd0, mon_e.data});
                check("parity_err", {31'd0, parity_err_o}, {31'd0, mon_e.perr});
                check("frame_err", {31'd0, frame_err_o}, {31'd0, mon_e.ferr});
                check("valid_cycle",
                      ((cyc >= mon_e.exp_cyc - 1) && (cyc <= mon_e.exp_cyc + 1)) ?
                          mon_e.exp_cyc : cyc,
                      mon_e.exp_cyc);
            end
        end
        prev_valid = rx_valid_o;
    end

    // Called on a falling edge; holds the line level for p cycles.
    task automatic drive_bit(input logic v, input int p);
        rx_i = v;
        repeat (p) @(negedge clk_i);
    endtask

    // Sends one frame with the current configuration inputs. The valid pulse
    // is expected at: start edge + 2 synchronizer cycles + 1 cycle to enter
    // START + floor(P/2) + one full period per remaining sample.
    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic stopv, input int mid_period);
        int   p   = eff_period(int'(bit_period_i));
        logic pen = parity_en_i;
        int   ns  = stopbit_i ? 2 : 1;
        exp_t e;
        e.data    = d;
        e.perr    = pen ? (pbit ^ (^d)) : 1'b0;
        e.ferr    = ~stopv;
        e.exp_cyc = cyc + 3 + p / 2 + (8 + int'(pen) + ns) * p;
        sb.push_back(e);
        n_pushed++;
        drive_bit(1'b0, p);
        if (mid_period != 0) bit_period_i = 16'(mid_period);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        repeat (ns) drive_bit(stopv, p);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (((sb.size() != 0) || (busy_o !== 1'b0)) && (n < 20000)) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, sb.size(), 32'd0);
    endtask

    logic [7:0] nominal [5] = '{8'h1C, 8'h0D, 8'h0D, 8'h7F, 8'h7F};
    int         cfg_per [3] = '{32, 8, 24};
    logic       cfg_pen [3] = '{1'b1, 1'b1, 1'b0};
    logic       cfg_st  [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        int   p0;
        int   p;
        logic seen_busy;

        rx_i         = 1'b1;
        resetn_i     = 1'b0;
        bit_period_i = 16'd868;
        parity_en_i  = 1'b1;
        stopbit_i    = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset_data", {24'd0, rx_data_o}, 32'd0);
        check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
        check("reset_perr", {31'd0, parity_err_o}, 32'd0);
        check("reset_ferr", {31'd0, frame_err_o}, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        resetn_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // Nominal 115200 baud, parity + two stop bits, back-to-back frames.
        // All five bytes have an odd number of ones, so parity bit 1 is correct.
        foreach (nominal[i]) send_frame(nominal[i], 1'b1, 1'b1, 0);
        drain("nominal_drain");
        check("nominal_pulses", n_pulses, 32'd5);

        // Parity error: 0x55 has four ones, so even parity wants 0.
        bit_period_i = 16'd64;
        send_frame(8'h55, 1'b1, 1'b1, 0);
        drain("parity_drain");
        repeat (100) @(negedge clk_i);
        check("hold_data", {24'd0, rx_data_o}, 32'h55);
        check("hold_perr", {31'd0, parity_err_o}, 32'd1);

        // Framing error followed by a 30-bit break: exactly one pulse.
        p0 = n_pulses;
        send_frame(8'hA3, 1'b0, 1'b0, 0);   // 0xA3: four ones, parity 0
        drive_bit(1'b0, 30 * 64);
        check("break_pulses", n_pulses, p0 + 1);
        check("break_busy", {31'd0, busy_o}, 32'd0);
        drive_bit(1'b1, 2 * 64);
        // Clean frame after break; period changed mid-frame must be ignored.
        send_frame(8'h3C, 1'b0, 1'b1, 200);  // 0x3C: four ones, parity 0
        bit_period_i = 16'd64;
        drain("after_break_drain");
        check("after_break_ferr", {31'd0, frame_err_o}, 32'd0);

        // 200 ns glitch on an idle line.
        p0        = n_pulses;
        seen_busy = 1'b0;
        rx_i      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) rx_i = 1'b1;
            @(negedge clk_i);
            seen_busy |= busy_o;
        end
        for (int i = 0; (i < 200) && (busy_o !== 1'b0); i++) @(negedge clk_i);
        check("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
        check("glitch_idle", {31'd0, busy_o}, 32'd0);
        check("glitch_no_pulse", n_pulses, p0);

        // Reset during data bit 4 of 0xF0, then 0x81, for three configurations.
        for (int c = 0; c < 3; c++) begin
            bit_period_i = 16'(cfg_per[c]);
            parity_en_i  = cfg_pen[c];
            stopbit_i    = cfg_st[c];
            p            = eff_period(cfg_per[c]);
            p0           = n_pulses;
            for (int b = 0; b < 5; b++) drive_bit(1'b0, p);   // start + bits 0..3
            drive_bit(1'b1, p / 2);                          // into bit 4
            resetn_i = 1'b0;
            repeat (2) @(negedge clk_i);
            check("rst_data", {24'd0, rx_data_o}, 32'd0);
            check("rst_valid", {31'd0, rx_valid_o}, 32'd0);
            check("rst_perr", {31'd0, parity_err_o}, 32'd0);
            check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
            check("rst_busy", {31'd0, busy_o}, 32'd0);
            resetn_i = 1'b1;
            repeat (p) @(negedge clk_i);
            check("rst_no_pulse", n_pulses, p0);
            send_frame(8'h81, 1'b0, 1'b1, 0);  // 0x81: two ones, parity 0
            drain("rst_recover_drain");
        end

        check("total_pulses", n_pulses, n_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
